// File: rtl/aes_dec.sv
// AES-128 inverse cipher: decrypts one 128-bit block using the original cipher key.
// Latency: 20 cycles from capture to the res_valid_out pulse (10 key-expansion + 10 inverse rounds).
// Backpressure: none; a start is accepted only while ready_out=1, and starts seen while busy are dropped.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   data_valid_in        start request, sampled only while ready_out=1
//   data_in, key_in      ciphertext and cipher key; bits [127:120] hold state byte 0, column-major
//   res_dec_out          plaintext, registered, held until the next result
//   res_valid_out        one-cycle pulse when res_dec_out is updated
//   ready_out            high while idle
module aes_dec (
  input  logic         clk,
  input  logic         resetn,
  input  logic         data_valid_in,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] res_dec_out,
  output logic         res_valid_out,
  output logic         ready_out
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} fsm_e;

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   rnd_q;
  logic [7:0]   rcon_q;

  logic [127:0] key_fwd_d;
  logic [127:0] key_prev_d;
  logic [127:0] ark_d;
  logic [127:0] round_d;
  logic [7:0]   rcon_inv_d;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic. The S-boxes are built from the field inverse plus the
  // affine transform rather than stored as tables.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: w3 has to be recovered first because w0 depends on it.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------------------------------------------------------------------
  // Inverse round transforms. Byte k lives at bits [127-8k -: 8]; byte k is
  // row k%4, column k/4.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath next-state values
  // ---------------------------------------------------------------------------
  assign key_fwd_d  = key_fwd(key_q, rcon_q);
  assign key_prev_d = key_inv(key_q, rcon_q);
  assign ark_d      = inv_sub_bytes(inv_shift_rows(state_q)) ^ key_prev_d;
  // The last inverse round has no InvMixColumns.
  assign round_d    = (rnd_q == 4'd0) ? ark_d : inv_mix_columns(ark_d);
  // Walk rcon backwards: 0x1b came from 0x80, everything else halves.
  assign rcon_inv_d = (rcon_q == 8'h1b) ? 8'h80 : {1'b0, rcon_q[7:1]};

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fsm_q         <= IDLE;
      state_q       <= '0;
      key_q         <= '0;
      rnd_q         <= '0;
      rcon_q        <= '0;
      res_dec_out   <= '0;
      res_valid_out <= 1'b0;
      ready_out     <= 1'b1;
    end else begin
      res_valid_out <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (data_valid_in) begin
            state_q   <= data_in;
            key_q     <= key_in;
            rnd_q     <= 4'd0;
            rcon_q    <= 8'h01;
            ready_out <= 1'b0;
            fsm_q     <= KEXP;
          end
        end
        KEXP: begin
          key_q <= key_fwd_d;
          if (rnd_q == 4'd9) begin
            // K10 is ready on this edge: fold in the initial AddRoundKey and
            // prime rcon with the value used to produce K10.
            state_q <= state_q ^ key_fwd_d;
            rnd_q   <= 4'd9;
            rcon_q  <= 8'h36;
            fsm_q   <= ROUND;
          end else begin
            rnd_q  <= rnd_q + 4'd1;
            rcon_q <= xtime(rcon_q);
          end
        end
        ROUND: begin
          state_q <= round_d;
          key_q   <= key_prev_d;
          rcon_q  <= rcon_inv_d;
          if (rnd_q == 4'd0) begin
            res_dec_out   <= round_d;
            res_valid_out <= 1'b1;
            ready_out     <= 1'b1;
            fsm_q         <= IDLE;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: begin
          fsm_q     <= IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_dec.md
# aes_dec

AES-128 decryption core: the inverse-cipher counterpart to the `aes` encryption core, with the same handshake style. It accepts a 128-bit ciphertext and the original cipher key, expands the key forward to round key 10, then runs 10 iterative inverse rounds while deriving round keys backwards on the fly. It presents the plaintext with a one-cycle valid pulse and sits beside `aes` in the datapath, on the receive/decrypt side.

## Interface
- No parameters. Fixed to AES-128: 10 rounds, 128-bit key.
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- data_valid_in  in  1  start request; sampled only while ready_out=1.
- data_in  in  128  ciphertext; data_in[127:120] is state byte 0; bytes fill column-major.
- key_in  in  128  cipher key (round key 0), same byte order as data_in; sampled with data_valid_in.
- res_dec_out  out  128  plaintext; registered; holds its value until the next result.
- res_valid_out  out  1  one-cycle pulse when res_dec_out is updated.
- ready_out  out  1  high in IDLE; start requests are accepted only when it is high.

## Operation
- FSM states: IDLE, KEXP, ROUND.
- Registers:
  - state_q (128 bits)
  - key_q (128 bits)
  - rnd_q (4 bits)
  - rcon_q (8 bits)
  - res_dec_out
  - res_valid_out
- IDLE, with data_valid_in=1:
  - state_q←data_in, key_q←key_in, rnd_q←0, rcon_q←0x01.
  - Go to KEXP.
  - data_valid_in=0 in IDLE: no state change.
- KEXP: forward key-schedule step each cycle.
  - w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, then w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rcon_q←xtime(rcon_q); 0x80 steps to 0x1b.
  - rnd_q increments.
  - On the 10th step (rnd_q=9), key_q becomes K10 and state_q←state_q^K10 in the same edge.
  - Then: rnd_q←9, rcon_q←0x36, go to ROUND.
- ROUND: each cycle computes Kprev=InvStep(key_q) combinationally.
  - InvStep: w3=w3'^w2', w2=w2'^w1', w1=w1'^w0', w0=w0'^SubWord(RotWord(w3))^{rcon_q,24'h0}, where w3 is the recovered word.
  - state_q←InvMixColumns(InvSubBytes(InvShiftRows(state_q))^Kprev).
  - InvMixColumns is skipped when rnd_q=0.
  - key_q←Kprev.
  - rcon_q←inverse xtime: 0x1b steps to 0x80, otherwise shift right by 1.
  - rnd_q decrements.
- ROUND with rnd_q=0: load the round result into res_dec_out, res_valid_out←1, go to IDLE.
- data_valid_in while not in IDLE is ignored: no queueing, no corruption of the operation in flight.
- res_valid_out is cleared on every edge on which it is not being set.
- InvSubBytes uses the inverse S-box; SubWord uses the forward S-box; both are combinational lookups.

## Timing
- Reset (resetn=0 at an edge): all outputs and registers are zero, except ready_out=1. FSM goes to IDLE.
- Reset asserted mid-operation aborts on that edge; no res_valid_out pulse is produced.
- Capture edge E0 (IDLE, data_valid_in=1) → ready_out=0 after E0.
- KEXP occupies edges E1..E10. ROUND occupies edges E11..E20.
- res_valid_out=1 and res_dec_out valid from E20 to E21. Latency is 20 cycles.
- ready_out=1 after E20; the earliest next capture is E21, so throughput is 1 block per 21 cycles.
- Back-to-back: data_valid_in held high through E21 starts the next block at E21. The result pulse is unaffected.

## Test plan
- Vector 1 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → res_dec_out=00112233445566778899aabbccddeeff; res_valid_out pulses exactly 20 cycles after capture, width 1.
- Vector 2 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
- Vector 3: key 0, ct 66e94bd4ef8a2c3b884cfa59ca342b2e → plaintext 0.
- Busy rejection: start Vector 1, then pulse data_valid_in with Vector 2 at E5 → only one result (Vector 1 plaintext), ready_out low E1..E20.
- Reset mid-op: assert resetn=0 at E12 for 2 cycles → no res_valid_out pulse, outputs 0, ready_out=1. A subsequent Vector 2 decrypts correctly.
- Round-trip: the encrypt/decrypt vector files (ciphertext→plaintext swapped) and `aes` output chained into aes_dec with random keys → all plaintexts recovered; each completes in 20 cycles.
